fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch front end; consumes the writeback stage's PC-update interface (writeback_update_pc/next_pc).
//  Owns the architectural PC, issues one instruction-memory read at a time via valid/ready.
//  Captures the response; presents the instruction to decode until accepted.
//  One instruction in flight: next fetch starts only after writeback supplies the next PC.
// PARAMETERS
//  RESET_PC  default `ALEN'h0  PC loaded on reset; first fetch address
// PORTS
//  clk                          in   1      clock; all state updates on posedge
//  rst                          in   1      synchronous, active-high reset
//  writeback_update_pc          in   1      writeback retired an instruction; next_pc valid
//  writeback_next_pc            in   ALEN   PC of next instruction (branch/trap/xret/sequential)
//  imem_req_valid               out  1      read request valid
//  imem_req_ready               in   1      memory accepts request this cycle
//  imem_req_addr                out  ALEN   read address
//  imem_resp_valid              in   1      response valid (exactly one per accepted request)
//  imem_resp_data               in   32     instruction word
//  imem_resp_fault              in   1      access fault for this response
//  next_stalled                 in   1      decode cannot accept this cycle
//  fetch_valid                  out  1      instruction outputs valid
//  fetch_instruction            out  32     instruction word (32'h0 on fault)
//  fetch_instruction_addr       out  ALEN   PC of instruction
//  fetch_instruction_next_addr  out  ALEN   PC + 4 (wraps modulo 2^ALEN)
//  fetch_fault                  out  1      instruction fetch fault
// BEHAVIOUR
//  FSM: BOOT -> REQ -> RESP -> VALID -> WAIT_WB -> REQ ...
//   BOOT: entered on rst; req_valid=0, fetch_valid=0; unconditionally -> REQ next cycle.
//   REQ: req_valid=1, addr=pc. On ready -> RESP. Addr/valid held stable until ready.
//   RESP: wait resp_valid; latch data/fault; -> VALID (or REQ if stale, below).
//   VALID: fetch_valid=1; on !next_stalled -> WAIT_WB. Outputs stable while stalled.
//   WAIT_WB: on writeback_update_pc: pc <= writeback_next_pc, -> REQ.
//  Reset values: pc=RESET_PC, state=BOOT, all outputs 0, stale=0; reset mid-request
//   abandons it; a response arriving after reset is ignored (no request outstanding).
//  Latency: update_pc in cycle N -> req_valid N+1; ready at N+1, resp at N+2 -> fetch_valid N+3.
//  fetch_* outputs registered; imem_req_* decoded from state/pc.
//  Redirect outside WAIT_WB (writeback_update_pc in REQ/RESP/VALID):
//   pc <= next_pc, stale=1. REQ: current request still completes (stability rule).
//   RESP: returned response discarded, -> REQ with new pc, stale=0.
//   VALID: held instruction dropped (fetch_valid=0 next cycle), -> REQ.
//   Simultaneous redirect and decode accept in VALID: accept counts, then -> REQ (not WAIT_WB).
//  Response when not in RESP: ignored. next_addr = pc + 4, carry out discarded.
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: pc[1:0]!=0 in REQ issues no request; -> VALID with
//   fetch_fault=1, fetch_instruction=32'h0.
//  Not defined: address passed to memory unmodified; alignment is the memory's problem.
// STRUCTURE
//  fetch_state_t enum (BOOT,REQ,RESP,VALID,WAIT_WB) in shared core package; widths via `ALEN.
//  No sub-module: single flat FSM + PC/response registers.
// TESTING
//  Reset, ready=1, resp 1 cycle later, data 32'h00000013 -> req addr=RESET_PC; fetch_valid, next_addr=RESET_PC+4.
//  Hold ready=0 3 cycles -> req_valid/addr stable throughout; fetch_valid 2 cycles after ready.
//  next_stalled=1 for 4 cycles in VALID -> outputs unchanged; deassert -> WAIT_WB, no new req until update_pc.
//  update_pc=1, next_pc='h100 while in RESP -> response discarded; next req addr='h100.
//  imem_resp_fault=1 -> fetch_fault=1, fetch_instruction=0; pc='hFFFFFFFC -> next_addr=0.
//  With FETCH_MISALIGN_CHECK_EN, next_pc='h102 -> no req_valid; fetch_fault=1 two cycles later.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared core package for the fetch front end.
//   ALEN          : address width, taken from the `ALEN macro (32 if not defined)
//   fetch_state_t : fetch FSM states
//   addr_t        : ALEN-wide address type
//   next_seq_pc() : sequential successor PC, wrapping modulo 2^ALEN
`ifndef ALEN
`define ALEN 32
`endif

package fetch_unit_pkg;

  localparam int ALEN = `ALEN;

  typedef logic [ALEN-1:0] addr_t;

  typedef enum logic [2:0] {
    BOOT,
    REQ,
    RESP,
    VALID,
    WAIT_WB
  } fetch_state_t;

  localparam addr_t INSTR_BYTES = addr_t'(4);

  // Carry out of the top bit is dropped, so the last word wraps to address 0.
  function automatic addr_t next_seq_pc(input addr_t pc);
    return pc + INSTR_BYTES;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read interface (one request/response pair at a time).
//   req_valid  : request valid             (master -> slave)
//   req_ready  : slave accepts request     (slave  -> master)
//   req_addr   : read address              (master -> slave)
//   resp_valid : response valid            (slave  -> master)
//   resp_data  : 32-bit instruction word   (slave  -> master)
//   resp_fault : access fault for response (slave  -> master)
// Modports: master (fetch unit), slave (memory).
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  addr_t       req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_fault;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_fault
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end. Owns the architectural PC, issues one
// instruction-memory read at a time and holds the returned instruction for
// decode until accepted. The next fetch starts only once writeback supplies
// the next PC.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   writeback_update_pc/next_pc : writeback retired an instruction; next PC
//   imem (master)               : instruction-memory request/response
//   next_stalled                : decode cannot accept this cycle
//   fetch_*                     : registered instruction outputs to decode
// Build option: FETCH_MISALIGN_CHECK_EN -- when defined, a PC with
// pc[1:0] != 0 issues no request and produces a fault instruction instead.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                writeback_update_pc,
  input  addr_t               writeback_next_pc,
  fetch_unit_if.master        imem,
  input  logic                next_stalled,
  output logic                fetch_valid,
  output logic [31:0]         fetch_instruction,
  output addr_t               fetch_instruction_addr,
  output addr_t               fetch_instruction_next_addr,
  output logic                fetch_fault
);

  fetch_state_t state_q, state_d;
  addr_t        pc_q, pc_d;
  // Redirect target captured while a request is being presented; the
  // presented address must not change until the memory accepts it.
  addr_t        pend_pc_q, pend_pc_d;
  // The outstanding request belongs to a superseded PC; drop its response.
  logic         stale_q, stale_d;

  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  addr_t        iaddr_q, iaddr_d;
  addr_t        inext_q, inext_d;
  logic         fault_q, fault_d;

  logic         req_valid;

  // NOTE: every signal gets its hold value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    stale_d   = stale_q;
    valid_d   = valid_q;
    instr_d   = instr_q;
    iaddr_d   = iaddr_q;
    inext_d   = inext_q;
    fault_d   = fault_q;
    req_valid = 1'b0;

    case (state_q)
      BOOT: state_d = REQ;

      REQ: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (pc_q[1:0] != 2'b00) begin
          // Nothing is outstanding, so a redirect simply replaces the PC.
          if (writeback_update_pc) begin
            pc_d = writeback_next_pc;
          end else begin
            state_d = VALID;
            valid_d = 1'b1;
            instr_d = 32'h0;
            iaddr_d = pc_q;
            inext_d = next_seq_pc(pc_q);
            fault_d = 1'b1;
          end
        end else
`endif
        begin
          req_valid = 1'b1;
          if (writeback_update_pc) begin
            pend_pc_d = writeback_next_pc;
            stale_d   = 1'b1;
          end
          if (imem.req_ready) begin
            state_d = RESP;
            // Address is no longer presented; the redirect can take effect.
            if (writeback_update_pc) pc_d = writeback_next_pc;
            else if (stale_q)        pc_d = pend_pc_q;
          end
        end
      end

      RESP: begin
        if (writeback_update_pc) begin
          pc_d    = writeback_next_pc;
          stale_d = 1'b1;
        end
        if (imem.resp_valid) begin
          if (stale_q || writeback_update_pc) begin
            state_d = REQ;
            stale_d = 1'b0;
          end else begin
            state_d = VALID;
            valid_d = 1'b1;
            instr_d = imem.resp_fault ? 32'h0 : imem.resp_data;
            iaddr_d = pc_q;
            inext_d = next_seq_pc(pc_q);
            fault_d = imem.resp_fault;
          end
        end
      end

      VALID: begin
        // No request is outstanding here, so a redirect needs no stale mark;
        // a simultaneous decode accept still counts, but fetch restarts.
        if (writeback_update_pc) begin
          pc_d    = writeback_next_pc;
          valid_d = 1'b0;
          state_d = REQ;
        end else if (!next_stalled) begin
          valid_d = 1'b0;
          state_d = WAIT_WB;
        end
      end

      WAIT_WB: begin
        if (writeback_update_pc) begin
          pc_d    = writeback_next_pc;
          state_d = REQ;
        end
      end

      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      stale_q   <= 1'b0;
      valid_q   <= 1'b0;
      instr_q   <= 32'h0;
      iaddr_q   <= '0;
      inext_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      stale_q   <= stale_d;
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      iaddr_q   <= iaddr_d;
      inext_q   <= inext_d;
      fault_q   <= fault_d;
    end
  end

  assign imem.req_valid              = req_valid;
  assign imem.req_addr               = pc_q;
  assign fetch_valid                 = valid_q;
  assign fetch_instruction           = instr_q;
  assign fetch_instruction_addr      = iaddr_q;
  assign fetch_instruction_next_addr = inext_q;
  assign fetch_fault                 = fault_q;

endmodule
